// File: rtl/mdu_pkg.sv
// Shared types and op-class helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MTHI  = 3'd1,
        OP_MTLO  = 3'd2,
        OP_MULT  = 3'd3,
        OP_MULTU = 3'd4,
        OP_DIV   = 3'd5,
        OP_DIVU  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_t;

    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider: magnitudes in, one quotient bit per
// cycle, sign and divide-by-zero fix-up applied on the way out.
module div_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             active_q, active_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
    logic [WIDTH:0]   rem_sh, diff;

    function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        return (sgn && xs < 0) ? -xs : xs;
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic neg, input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        return neg ? -xs : xs;
    endfunction

    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        if (abort) begin
            active_d = 1'b0;
        end else if (start) begin
            active_d  = 1'b1;
            cnt_d     = CW'(WIDTH);
            rem_d     = '0;
            quo_d     = mag(is_sgn, a);
            dvs_d     = mag(is_sgn, b);
            dvd_d     = a;
            neg_quo_d = is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = is_sgn && a[WIDTH-1];
            zero_d    = (b == '0);
        end else if (active_q) begin
            if (cnt_q != '0) begin
                // Restore by keeping the shifted partial remainder when the trial subtract underflows.
                rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q - CW'(1);
            end else begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
        end
    end

    assign done = active_q && (cnt_q == '0) && !abort;
    assign quo  = zero_q ? '1    : sign_fix(neg_quo_q, quo_q);
    assign rem  = zero_q ? dvd_q : sign_fix(neg_rem_q, rem_q);

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register owner executing MTHI/MTLO/MULT(U)/DIV(U) as a multi-cycle slave.
// Define HILO_FWD_EN to bypass the values being written onto hi/lo in the done cycle.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int PW = 2 * WIDTH;

    mdu_state_t             state_q, state_d;
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic [PW-1:0]          mul_prod_q [MUL_STAGES];
    logic [PW-1:0]          mul_prod_d [MUL_STAGES];
    logic [MUL_STAGES-1:0]  mul_vld_q, mul_vld_d;
    logic signed [PW-1:0]   mul_a_ext, mul_b_ext, mul_prod;
    logic                   accept, mul_start, div_start, div_done;
    logic [WIDTH-1:0]       div_quo, div_rem;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = req_valid && req_ready && !flush
                       && (req_op != OP_NONE) && (req_op <= OP_DIVU);
    assign mul_start = accept && is_mul(req_op);
    assign div_start = accept && is_div(req_op);

    // Operands are consumed straight from the request in the accept cycle.
    assign mul_a_ext = is_signed(req_op) ? {{WIDTH{req_a[WIDTH-1]}}, req_a} : {{WIDTH{1'b0}}, req_a};
    assign mul_b_ext = is_signed(req_op) ? {{WIDTH{req_b[WIDTH-1]}}, req_b} : {{WIDTH{1'b0}}, req_b};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    div_seq #(.WIDTH(WIDTH)) u_div (
        .clk    (clk),
        .rst_n  (resetn),
        .start  (div_start),
        .abort  (flush),
        .is_sgn (is_signed(req_op)),
        .a      (req_a),
        .b      (req_b),
        .done   (div_done),
        .quo    (div_quo),
        .rem    (div_rem)
    );

    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done          = 1'b0;
        mul_vld_d[0]  = mul_start;
        mul_prod_d[0] = mul_prod;
        for (int i = 1; i < MUL_STAGES; i++) begin
            mul_vld_d[i]  = mul_vld_q[i-1];
            mul_prod_d[i] = mul_prod_q[i-1];
        end
        if (flush) mul_vld_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_op == OP_MTHI) begin
                        hi_d = req_a;
                        done = 1'b1;
                    end else if (req_op == OP_MTLO) begin
                        lo_d = req_a;
                        done = 1'b1;
                    end else if (is_div(req_op)) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mul_vld_q[MUL_STAGES-1]) begin
                    {hi_d, lo_d} = mul_prod_q[MUL_STAGES-1];
                    done         = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_vld_q <= '0;
            for (int i = 0; i < MUL_STAGES; i++) mul_prod_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mul_vld_q  <= mul_vld_d;
            mul_prod_q <= mul_prod_d;
        end
    end

`ifdef HILO_FWD_EN
    assign hi = hi_d;
    assign lo = lo_d;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized scoreboard bench for hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;
    localparam int W       = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = W + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [W-1:0]  req_a = '0, req_b = '0;
    logic          flush = 1'b0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    hilo_mdu #(.WIDTH(W), .MUL_STAGES(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         pe;
    bit           pend = 1'b0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] mhi = '0, mlo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the architectural HI/LO pair.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        longint          p, q, r;
        longint unsigned pu;
        lat = 0;
        case (op)
            3'd1: mhi = a;
            3'd2: mlo = a;
            3'd3: begin p = longint'($signed(a)) * longint'($signed(b)); {mhi, mlo} = p; lat = MUL_LAT; end
            3'd4: begin pu = 64'(a) * 64'(b); {mhi, mlo} = pu; lat = MUL_LAT; end
            3'd5, 3'd6: begin
                lat = DIV_LAT;
                if (b == '0) begin
                    mlo = '1;
                    mhi = a;
                end else if (op == 3'd5) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    mlo = q[W-1:0];
                    mhi = r[W-1:0];
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
            default: lat = 0;
        endcase
    endtask

    // Called at posedge+1; request is presented for exactly one cycle.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track);
        int lat;
        exp_t e;
        chk("ready_at_issue", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        if (track) begin
            model(op, a, b, lat);
            e.hi = mhi; e.lo = mlo; e.cyc = cyc + lat;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0; req_a = $urandom; req_b = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || pend || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_idle: timeout with %0d outstanding, expected 0", sbq.size());
            sbq.delete();
            pend = 1'b0;
        end
    endtask

    task automatic cycles_until(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops on every done, checks latency now and hi/lo one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("hi_after_done", hi, pe.hi);
                chk("lo_after_done", lo, pe.lo);
                pend = 1'b0;
            end
            if (resetn && done) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    pe = sbq.pop_front();
                    chk("done_cycle", cyc, pe.cyc);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, sel;
        logic [2:0] op;
        logic [W-1:0] a, b;
        exp_t e;

        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        issue(3'd1, 32'h12345678, 32'h0, 1'b1);
        chk("mt_busy", {31'b0, busy}, 32'd0);
        issue(3'd2, 32'hCAFEBABE, 32'h0, 1'b1);
        chk("mt_busy2", {31'b0, busy}, 32'd0);
        wait_idle();

        issue(3'd3, 32'hFFFFFFFD, 32'd5, 1'b1); wait_idle();
        issue(3'd4, 32'hFFFFFFFD, 32'd5, 1'b1); wait_idle();
        issue(3'd6, 32'd100, 32'd7, 1'b1);      wait_idle();
        issue(3'd5, 32'hFFFFFFF9, 32'd2, 1'b1); wait_idle();
        issue(3'd5, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_idle();
        issue(3'd5, 32'd5, 32'd0, 1'b1);        wait_idle();
        issue(3'd6, 32'd5, 32'd0, 1'b1);        wait_idle();

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(1, 6));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            issue(op, a, b, 1'b1);
            wait_idle();
        end

        // Flush mid-divide, flush in the done cycle (divide and multiply), flush in IDLE.
        issue(3'd1, 32'hAA, 32'h0, 1'b1);
        issue(3'd2, 32'hBB, 32'h0, 1'b1);
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            acc = cyc;
            issue((k == 2) ? 3'd3 : 3'd6, 32'd1000, 32'd3, 1'b0);
            cycles_until(acc + ((k == 0) ? 10 : (k == 1) ? DIV_LAT : MUL_LAT));
            flush = 1'b1;
            @(negedge clk);
            chk("flush_done", {31'b0, done}, 32'd0);
            @(posedge clk); #1;
            flush = 1'b0;
            chk("flush_busy", {31'b0, busy}, 32'd0);
            chk("flush_hi", hi, 32'hAA);
            chk("flush_lo", lo, 32'hBB);
        end
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'h55; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_hi", hi, 32'hAA);
        chk("idle_flush_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-divide.
        issue(3'd6, 32'd12345, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        mhi = '0; mlo = '0;
        #1;
        chk("arst_hi", hi, '0);
        chk("arst_lo", lo, '0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        // MULT held on the request lines while a DIV is in flight.
        acc = cyc;
        issue(3'd5, 32'hFFFFFF38, 32'd9, 1'b1);
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'h00012345; req_b = 32'hFFFF0003;
        while (cyc < acc + DIV_LAT + 1) begin
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("ready_after_done", {31'b0, req_ready}, 32'd1);
        model(3'd3, req_a, req_b, lat);
        e.hi = mhi; e.lo = mlo; e.cyc = cyc + lat;
        sbq.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        chk("stall_mul_busy", {31'b0, busy}, 32'd1);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
